// File: rtl/riscv_pkg.sv
// Shared front-end constants and the fetch buffer entry type.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the instruction buffer and the in-flight address queue.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int  DEPTH = 2,
  parameter  type T     = fetch_entry_t,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output T              o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot the push needs, so push+pop is legal when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited memory requests, output buffer, redirect.
// Optional FETCH_BYPASS_EN forwards a response straight to the decoder when the buffer is empty.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_redir_pc;
  logic            r_redir_pend;
  logic [CW-1:0]   r_discard;

  logic [CW-1:0]   w_aq_count;
  logic [CW-1:0]   w_oq_count;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW:0]     w_credit_used;
  logic            w_aq_full, w_aq_empty, w_oq_full, w_oq_empty;
  logic [XLEN-1:0] w_aq_head;
  fetch_entry_t    w_oq_head;
  fetch_entry_t    w_oq_entry;
  logic            w_accept, w_resp, w_resp_keep, w_bypass;
  logic            w_fire, w_redirect, w_oq_push, w_oq_pop;
  logic [XLEN-1:0] w_target;

  // The address queue occupancy is the outstanding-request count, stale ones included.
  assign w_credit_used  = {1'b0, w_aq_count} + {1'b0, w_oq_count};
  assign imem_req_valid = reset && (w_credit_used < (CW+1)'(FIFO_DEPTH)) && !w_aq_full && !w_oq_full;
  assign imem_addr      = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_resp      = imem_resp_valid && !w_aq_empty;
  assign w_resp_keep = w_resp && (r_discard == '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_oq_empty && w_resp_keep;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid = !w_oq_empty || w_bypass;
  assign instruction = w_bypass ? imem_resp_data : w_oq_head.instr;
  assign instr_pc    = w_bypass ? w_aq_head : w_oq_head.pc;

  assign w_fire     = instr_valid && instr_ready;
  assign w_redirect = w_fire && pc_src;
  assign w_oq_pop   = w_fire && !w_oq_empty;
  assign w_oq_push  = w_resp_keep && !(w_bypass && instr_ready);
  assign w_oq_entry = '{pc: w_aq_head, instr: imem_resp_data};
  assign w_target   = branch_target & ~32'h3;

  assign w_outstanding_nxt = w_aq_count + CW'(w_accept) - CW'(w_resp);

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_addr_q (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_accept),
    .i_data  (r_fetch_pc),
    .i_pop   (w_resp),
    .i_flush (1'b0),
    .o_head  (w_aq_head),
    .o_count (w_aq_count),
    .o_full  (w_aq_full),
    .o_empty (w_aq_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_out_q (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_oq_push),
    .i_data  (w_oq_entry),
    .i_pop   (w_oq_pop),
    .i_flush (w_redirect),
    .o_head  (w_oq_head),
    .o_count (w_oq_count),
    .o_full  (w_oq_full),
    .o_empty (w_oq_empty)
  );

  // A request already presented keeps its address; the target is parked until it is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= RESET_PC;
      r_redir_pend <= 1'b0;
    end else if (w_redirect) begin
      if (imem_req_valid && !w_accept) begin
        r_redir_pend <= 1'b1;
        r_redir_pc   <= w_target;
      end else begin
        r_redir_pend <= 1'b0;
        r_fetch_pc   <= w_target;
      end
    end else if (w_accept) begin
      r_redir_pend <= 1'b0;
      r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_discard <= '0;
    end else if (w_redirect) begin
      r_discard <= w_outstanding_nxt;
    end else if (w_resp && (r_discard != '0)) begin
      r_discard <= r_discard - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, random and directed stimulus.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam int FIRST_LAT = BYPASS ? 1 : 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_src          (pc_src),
    .branch_target   (branch_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instruction     (instruction),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready)
  );

  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  infl_t        m_infl[$];
  fetch_entry_t m_ofifo[$];
  logic [31:0]  m_pc, m_tgt;
  bit           m_pend;
  mreq_t        mem_q[$];
  int           last_due, cyc, first_valid_cyc;
  logic [31:0]  acc_log[$], del_log[$];

  logic        exp_req_valid, exp_instr_valid;
  logic [31:0] exp_addr, exp_instr, exp_pc;
  bit          chk_en = 1'b0;
  int          n_pass = 0, n_total = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req_valid", imem_req_valid, exp_req_valid);
      if (exp_req_valid) check("imem_addr", imem_addr, exp_addr);
      check("instr_valid", instr_valid, exp_instr_valid);
      if (exp_instr_valid) begin
        check("instruction", instruction, exp_instr);
        check("instr_pc", instr_pc, exp_pc);
      end
    end
  end

  task automatic model_reset();
    m_infl.delete();
    m_ofifo.delete();
    mem_q.delete();
    acc_log.delete();
    del_log.delete();
    m_pc = RPC;
    m_tgt = RPC;
    m_pend = 1'b0;
    last_due = -1;
    cyc = -1;
    first_valid_cyc = -1;
  endtask

  // Asserts reset mid-cycle and checks the asynchronous reset values right away.
  task automatic full_reset();
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    reset = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    pc_src = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_imem_addr", imem_addr, RPC);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // mode 0: no redirect, 1: random redirects/targets, 2: redirect when delivering pc==match
  task automatic step(input bit rdy, input bit irdy, input int lat_lo, input int lat_hi,
                      input int mode, input logic [31:0] match, input logic [31:0] tgt_in);
    bit          resp, keep, byp, src, fire, redir, accept, push;
    logic [31:0] ra, tgt;
    mreq_t       mr;
    infl_t       e;
    int          due;
    @(posedge clk);
    #2;
    cyc++;
    imem_req_ready = rdy;
    instr_ready = irdy;
    resp = 1'b0;
    ra = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      mr = mem_q.pop_front();
      resp = 1'b1;
      ra = mr.addr;
    end
    imem_resp_valid = resp;
    imem_resp_data = resp ? mem_word(ra) : $urandom;

    exp_req_valid = (m_infl.size() + m_ofifo.size()) < DEPTH;
    exp_addr = m_pc;
    keep = resp && (m_infl.size() > 0) && !m_infl[0].stale;
    byp = BYPASS && keep && (m_ofifo.size() == 0);
    exp_instr_valid = (m_ofifo.size() > 0) || byp;
    if (byp) begin
      exp_pc = m_infl[0].addr;
      exp_instr = mem_word(m_infl[0].addr);
    end else if (m_ofifo.size() > 0) begin
      exp_pc = m_ofifo[0].pc;
      exp_instr = m_ofifo[0].instr;
    end else begin
      exp_pc = '0;
      exp_instr = '0;
    end
    if (exp_instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    tgt = tgt_in;
    if (mode == 1) begin
      src = ($urandom_range(0, 3) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    end else if (mode == 2) begin
      src = exp_instr_valid && (exp_pc == match);
    end else begin
      src = 1'b0;
    end
    pc_src = src;
    branch_target = tgt;

    fire = exp_instr_valid && irdy;
    redir = fire && src;
    accept = exp_req_valid && rdy;
    if (fire) del_log.push_back(exp_pc);
    if (accept) acc_log.push_back(m_pc);

    push = 1'b0;
    if (resp && m_infl.size() > 0) begin
      e = m_infl.pop_front();
      push = !e.stale && !(byp && irdy);
    end
    if (fire && !byp) void'(m_ofifo.pop_front());
    if (push) m_ofifo.push_back('{pc: e.addr, instr: mem_word(e.addr)});
    if (accept) begin
      m_infl.push_back('{addr: m_pc, stale: 1'b0});
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{due: due, addr: m_pc});
      m_pc = m_pend ? m_tgt : m_pc + 32'd4;
      m_pend = 1'b0;
    end
    if (redir) begin
      m_ofifo.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      if (exp_req_valid && !accept) begin
        m_pend = 1'b1;
        m_tgt = tgt & ~32'h3;
      end else begin
        m_pc = tgt & ~32'h3;
        m_pend = 1'b0;
      end
    end
    chk_en = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_req_valid", imem_req_valid, 1'b0);
    check("init_instr_valid", instr_valid, 1'b0);
    check("init_imem_addr", imem_addr, RPC);
    @(negedge clk);
    reset = 1'b1;

    // latency 1, always ready
    repeat (12) step(1'b1, 1'b1, 1, 1, 0, 32'h0, 32'h0);
    check("seq_acc0", acc_log[0], 32'h0);
    check("seq_acc1", acc_log[1], 32'h4);
    check("seq_acc2", acc_log[2], 32'h8);
    check("seq_acc3", acc_log[3], 32'hC);
    check("seq_del0", del_log[0], 32'h0);
    check("seq_del1", del_log[1], 32'h4);
    check("seq_del2", del_log[2], 32'h8);
    check("first_valid_cycle", first_valid_cyc, FIRST_LAT);

    // decoder stalled: credits stop fetching at FIFO_DEPTH
    full_reset();
    repeat (6) step(1'b1, 1'b0, 1, 1, 0, 32'h0, 32'h0);
    check("stall_acc_count", acc_log.size(), DEPTH);
    check("stall_req_valid", exp_req_valid, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1, 1, 0, 32'h0, 32'h0);
    check("stall_del0", del_log[0], 32'h0);
    check("stall_del1", del_log[1], 32'h4);
    check("stall_resume", acc_log[2], 32'h8);

    // redirect on pc 4 to 0x100, latency 3
    full_reset();
    repeat (30) step(1'b1, 1'b1, 3, 3, 2, 32'h4, 32'h100);
    check("redir_del1", del_log[1], 32'h4);
    check("redir_del2", del_log[2], 32'h100);
    check("redir_del3", del_log[3], 32'h104);

    // unaligned target
    full_reset();
    repeat (25) step(1'b1, 1'b1, 1, 2, 2, 32'h8, 32'h203);
    check("align_del2", del_log[2], 32'h8);
    check("align_del3", del_log[3], 32'h200);

    // redirect while the pending request is held off by the memory
    full_reset();
    repeat (4) step(1'b1, 1'b1, 2, 2, 0, 32'h0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 2, 2, 2, 32'h4, 32'h300);
    repeat (12) step(1'b1, 1'b1, 2, 2, 0, 32'h0, 32'h0);

    // randomized traffic with redirects
    full_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 1, 4, 1, 32'h0, 32'h0);

    // asynchronous reset with requests in flight, then restart at RESET_PC
    full_reset();
    repeat (2) step(1'b1, 1'b1, 3, 3, 0, 32'h0, 32'h0);
    check("burst_outstanding", m_infl.size(), 2);
    full_reset();
    repeat (6) step(1'b1, 1'b1, 1, 1, 0, 32'h0, 32'h0);
    check("restart_acc0", acc_log[0], RPC);
    check("restart_del0", del_log[0], RPC);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
